// File: rtl/input_conditioner_if.sv
// Panel switch inputs and debounced controller levels.
// master drives the raw switches; slave is the conditioner.
interface input_conditioner_if;
  logic       raw_h;
  logic       raw_dc;
  logic       raw_c;
  logic       H;
  logic       DC;
  logic       C;
  logic [2:0] chg;

  modport master (
    output raw_h, raw_dc, raw_c,
    input  H, DC, C, chg
  );

  modport slave (
    input  raw_h, raw_dc, raw_c,
    output H, DC, C, chg
  );
endinterface

// File: rtl/input_conditioner.sv
// Synchronise and debounce three panel switches into clean
// registered levels plus one-cycle change pulses.
module input_conditioner #(
  parameter int unsigned TICK_DIV  = 1,
  parameter int unsigned DEB_TICKS = 4
) (
  input logic                CLK,
  input logic                reset,
  input_conditioner_if.slave io
);

  localparam int unsigned TW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TICK_DIV - 1);
  localparam logic [7:0]    CMAX = 8'(DEB_TICKS - 1);

  typedef enum logic [1:0] {
    LOW  = 2'b00,
    RISE = 2'b01,
    HIGH = 2'b10,
    FALL = 2'b11
  } st_e;

  logic [2:0]    raw;
  logic [2:0]    s1_d, s1_q;
  logic [2:0]    s2_d, s2_q;
  logic [2:0]    out_d, out_q;
  logic [2:0]    dly_d, dly_q;
  logic [TW-1:0] tc_d, tc_q;
  logic          tick;
  st_e           st_d [3];
  st_e           st_q [3];
  logic [7:0]    cnt_d [3];
  logic [7:0]    cnt_q [3];

  always_comb begin
    raw   = {io.raw_h, io.raw_dc, io.raw_c};
    s1_d  = raw;
    s2_d  = s1_q;
    dly_d = out_q;
    tick  = (tc_q == TMAX);
    tc_d  = tick ? '0 : tc_q + 1'b1;
    for (int i = 0; i < 3; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        case (st_q[i])
          LOW: if (s2_q[i]) begin
            st_d[i]  = RISE;
            cnt_d[i] = 8'd1;
          end
          RISE: if (!s2_q[i]) begin
            st_d[i]  = LOW;
            cnt_d[i] = 8'd0;
          end else if (cnt_q[i] == CMAX) begin
            st_d[i]  = HIGH;
            cnt_d[i] = 8'd0;
          end else begin
            cnt_d[i] = cnt_q[i] + 8'd1;
          end
          HIGH: if (!s2_q[i]) begin
            st_d[i]  = FALL;
            cnt_d[i] = 8'd1;
          end
          FALL: if (s2_q[i]) begin
            st_d[i]  = HIGH;
            cnt_d[i] = 8'd0;
          end else if (cnt_q[i] == CMAX) begin
            st_d[i]  = LOW;
            cnt_d[i] = 8'd0;
          end else begin
            cnt_d[i] = cnt_q[i] + 8'd1;
          end
          default: begin
            st_d[i]  = LOW;
            cnt_d[i] = 8'd0;
          end
        endcase
      end
      // Level follows the next state so it lands with the transition.
      out_d[i] = (st_d[i] == HIGH) || (st_d[i] == FALL);
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      s1_q  <= '0;
      s2_q  <= '0;
      out_q <= '0;
      dly_q <= '0;
      tc_q  <= '0;
      for (int i = 0; i < 3; i++) begin
        st_q[i]  <= LOW;
        cnt_q[i] <= 8'd0;
      end
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      out_q <= out_d;
      dly_q <= dly_d;
      tc_q  <= tc_d;
      for (int i = 0; i < 3; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign io.H   = out_q[2];
  assign io.DC  = out_q[1];
  assign io.C   = out_q[0];
  assign io.chg = out_q ^ dly_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed scenarios with a queued scoreboard checked on negedges.
// dut0 runs TICK_DIV=1, dut1 runs TICK_DIV=3; DEB_TICKS=4 on both.
module tb_input_conditioner;

  logic CLK = 1'b0;
  logic reset = 1'b1;
  always #5 CLK = ~CLK;

  input_conditioner_if if0 ();
  input_conditioner_if if1 ();

  input_conditioner #(.TICK_DIV(1), .DEB_TICKS(4)) dut0 (
    .CLK   (CLK),
    .reset (reset),
    .io    (if0.slave)
  );

  input_conditioner #(.TICK_DIV(3), .DEB_TICKS(4)) dut1 (
    .CLK   (CLK),
    .reset (reset),
    .io    (if1.slave)
  );

  typedef struct {
    bit         sel;
    logic [2:0] lvl;
    logic [2:0] chg;
    string      tag;
    int         k;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  always @(negedge CLK) begin
    exp_t       e;
    logic [2:0] al;
    logic [2:0] ac;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.sel) begin
        al = {if1.H, if1.DC, if1.C};
        ac = if1.chg;
      end else begin
        al = {if0.H, if0.DC, if0.C};
        ac = if0.chg;
      end
      total++;
      if (al !== e.lvl || ac !== e.chg) begin
        bad++;
        $display("FAIL %s k=%0d: got lvl=%b chg=%b, want lvl=%b chg=%b",
                 e.tag, e.k, al, ac, e.lvl, e.chg);
      end
    end
  end

  task automatic set_raw(bit sel, logic [2:0] v);
    if (sel) {if1.raw_h, if1.raw_dc, if1.raw_c} = v;
    else     {if0.raw_h, if0.raw_dc, if0.raw_c} = v;
  endtask

  task automatic push(bit sel, logic [2:0] lvl, logic [2:0] chg,
                      string tag, int k);
    exp_t e;
    e.sel = sel;
    e.lvl = lvl;
    e.chg = chg;
    e.tag = tag;
    e.k   = k;
    q.push_back(e);
  endtask

  // Reset with all switches pressed; both DUTs must read all-zero.
  task automatic do_reset(string tag);
    @(posedge CLK); #1;
    reset = 1'b1;
    set_raw(1'b0, 3'b111);
    set_raw(1'b1, 3'b111);
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      push(i[0], 3'b000, 3'b000, tag, i);
    end
  endtask

  function automatic bit on_at(int k, int on_s, int on_e,
                               int gap_s, int gap_e);
    return (k >= on_s) && (k <= on_e) &&
           !((k >= gap_s) && (k <= gap_e));
  endfunction

  // Edge 1 is the first edge after reset release sampling raw.
  // r/f: edge after which the level rises/falls (0 = never).
  task automatic scen(bit sel, string tag, logic [2:0] mask,
                      int n, int on_s, int on_e,
                      int gap_s, int gap_e, int r, int f);
    logic [2:0] lvl;
    logic [2:0] chg;
    @(posedge CLK); #1;
    reset = 1'b0;
    set_raw(1'b0, 3'b000);
    set_raw(1'b1, 3'b000);
    set_raw(sel, on_at(1, on_s, on_e, gap_s, gap_e) ? mask : 3'b000);
    push(sel, 3'b000, 3'b000, tag, 0);
    for (int k = 1; k <= n; k++) begin
      @(posedge CLK); #1;
      lvl = (r > 0 && k >= r && (f == 0 || k < f)) ? mask : 3'b000;
      chg = (r > 0 && (k == r || k == f)) ? mask : 3'b000;
      push(sel, lvl, chg, tag, k);
      set_raw(sel, on_at(k + 1, on_s, on_e, gap_s, gap_e) ?
                   mask : 3'b000);
    end
  endtask

  initial begin
    set_raw(1'b0, 3'b000);
    set_raw(1'b1, 3'b000);
    do_reset("rst0");
    scen(1'b0, "h_hold",    3'b100, 22, 1, 12, 0, -1, 6, 18);
    do_reset("rst1");
    scen(1'b0, "dc_glitch", 3'b010, 12, 1, 3,  0, -1, 0, 0);
    do_reset("rst2");
    scen(1'b0, "all3",      3'b111, 20, 1, 10, 0, -1, 6, 16);
    do_reset("rst3");
    scen(1'b0, "h_gap",     3'b100, 30, 1, 20, 9, 10, 6, 26);
    do_reset("rst4");
    scen(1'b0, "c_part",    3'b001, 4,  1, 99, 0, -1, 0, 0);
    do_reset("rst_mid");
    scen(1'b0, "c_rst",     3'b001, 20, 1, 12, 0, -1, 6, 18);
    do_reset("rst5");
    scen(1'b1, "t3_hold",   3'b100, 30, 1, 15, 0, -1, 12, 27);
    do_reset("rst6");
    scen(1'b1, "t3_pulse",  3'b100, 16, 1, 7,  0, -1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      if (q.size() == 0) break;
      @(negedge CLK);
    end
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter TICK_DIV, default 1: CLK cycles per sample tick, range 1..65535.
REQ-002 Parameter DEB_TICKS, default 4: consecutive equal ticks needed to accept a level change, range 2..255.
REQ-003 CLK  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 raw_h  input  1  unsynchronised heater request from the panel switch.
REQ-006 raw_dc  input  1  unsynchronised dehumidifier/DC request from the panel switch.
REQ-007 raw_c  input  1  unsynchronised cooler request from the panel switch.
REQ-008 H, DC, C  output  1 each  debounced, registered levels that feed the downstream Moore controller inputs of the same names.
REQ-009 chg  output  3  one-cycle pulse per channel, bit 2 = H, bit 1 = DC, bit 0 = C, asserted when that debounced output changed.

Function
REQ-010 Each raw input SHALL pass through a two-flop synchronizer (sync1 -> sync2); only sync2 is used by the filter.
REQ-011 The tick counter SHALL run 0..TICK_DIV-1 and wrap; tick is high in the cycle count==TICK_DIV-1; with TICK_DIV=1, tick is high every cycle.
REQ-012 Each channel SHALL have an independent 4-state FSM: LOW, RISE, HIGH, FALL, plus an 8-bit counter cnt; FSMs update only on tick cycles.
REQ-013 LOW: sync2=1 -> RISE with cnt=1; else stay. Output = 0.
REQ-014 RISE: sync2=0 -> LOW with cnt=0; sync2=1 and cnt==DEB_TICKS-1 -> HIGH with cnt=0; else cnt+1. Output = 0.
REQ-015 HIGH: sync2=0 -> FALL with cnt=1; else stay. Output = 1.
REQ-016 FALL: sync2=1 -> HIGH with cnt=0; sync2=0 and cnt==DEB_TICKS-1 -> LOW with cnt=0; else cnt+1. Output = 1.
REQ-017 H/DC/C SHALL be decoded from state, registered, and glitch-free.
REQ-018 Latency with TICK_DIV=1: edge 1 is the first edge sampling the new raw level; the output changes after edge DEB_TICKS+2.
REQ-019 Any pulse or gap shorter than DEB_TICKS ticks, as seen at sync2, SHALL NOT change the output.
REQ-020 chg[i] SHALL be high for exactly the cycle after output i changes, computed as the XOR of output i and its one-cycle-delayed copy.
REQ-021 Channels SHALL be fully independent; simultaneous changes on several channels SHALL produce simultaneous output changes and chg bits, with no priority.
REQ-022 cnt SHALL never exceed DEB_TICKS-1 and SHALL never wrap.
REQ-023 Illegal or unused state encodings SHALL go to LOW on the next tick.

Reset
REQ-024 When reset is asserted, the following SHALL clear to 0 immediately and independent of CLK: sync flops, tick counter, FSMs (LOW), cnt, H, DC, C, chg, and the delayed copies.
REQ-025 Reset asserted mid-debounce SHALL discard the partial count; after deassertion, a held raw level SHALL need the full DEB_TICKS+2 latency.
REQ-026 Outputs SHALL remain 0 while reset is high, regardless of raw inputs.

Verification (TICK_DIV=1, DEB_TICKS=4 unless stated)
REQ-027 Scenario: raw_h held 1 from edge 1 -> H=1 after edge 6; chg=3'b100 for one cycle after edge 6, then 3'b000.
REQ-028 Scenario: raw_dc high for 3 cycles only -> DC stays 0; chg stays 3'b000 throughout.
REQ-029 Scenario: raw_h, raw_dc, raw_c rise together, later fall together -> H, DC, C rise after the same edge; chg=3'b111 for one cycle; the fall mirrors this with DEB_TICKS+2 latency.
REQ-030 Scenario: H=1, then raw_h drops for 2 cycles and returns -> H stays 1; no chg pulse.
REQ-031 Scenario: raw_c held 1, reset pulsed after edge 4 -> C=0 after reset; C=1 only DEB_TICKS+2 edges after reset deasserts.
REQ-032 Scenario: TICK_DIV=3, raw_h held 1 -> H rises only after 4 ticks (12 cycles plus sync/alignment); a 7-cycle pulse is rejected.
